// File: rtl/kernel_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : kernel_run_ctrl
//  Purpose  : Runs an ap_ctrl_hs kernel NUM_RUNS times after reset, marks the
//             activity window on probe_out, checksums the kernel output stream
//             and reports status plus checksum serially as nibbles.
//  Revision : 1.0 - initial release
// ============================================================================
module kernel_run_ctrl #(
    parameter int NUM_RUNS    = 16,
    parameter int START_DELAY = 64,
    parameter int TIMEOUT     = 1048576,
    parameter int DOUT_W      = 32,
    parameter int CSUM_W      = 32
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    output logic              ap_start,
    input  logic              ap_ready,
    input  logic              ap_done,
    input  logic              ap_idle,
    input  logic              dout_write,
    input  logic [DOUT_W-1:0] dout_din,
    output logic              probe_out,
    output logic [3:0]        data_out,
    output logic              data_valid,
    output logic [15:0]       run_cnt,
    output logic              err
);

    localparam logic [2:0] c_ST_GAP    = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_RUN    = 3'd2;
    localparam logic [2:0] c_ST_REPORT = 3'd3;
    localparam logic [2:0] c_ST_DONE   = 3'd4;

    localparam int c_NIBBLES = CSUM_W / 4;
    localparam int c_GAP_W   = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam int c_TO_W    = $clog2(TIMEOUT + 1);
    localparam int c_REP_W   = $clog2(c_NIBBLES + 1);

    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(START_DELAY - 1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT - 1);
    localparam logic [c_REP_W-1:0] c_REP_LAST = c_REP_W'(c_NIBBLES);

    logic [2:0]         r_state;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic [c_TO_W-1:0]  r_to_cnt;
    logic [c_REP_W-1:0] r_rep_cnt;
    logic [CSUM_W-1:0]  r_csum;
    logic [15:0]        r_run_cnt;
    logic               r_err;
    logic               r_ap_start;
    logic               r_probe;
    logic [3:0]         r_data_out;
    logic               r_data_valid;

    logic [CSUM_W-1:0]  w_word;
    logic [CSUM_W-1:0]  w_rotl;
    logic [15:0]        w_run_next;
    logic               w_more_runs;
    logic               w_csum_en;
    logic               w_run_done;

    assign w_word      = CSUM_W'(dout_din);
    assign w_rotl      = {r_csum[CSUM_W-2:0], r_csum[CSUM_W-1]};
    assign w_run_next  = (r_run_cnt == 16'hFFFF) ? r_run_cnt : r_run_cnt + 16'd1;
    assign w_more_runs = (int'({16'd0, w_run_next}) < NUM_RUNS);
    assign w_csum_en   = dout_write && ((r_state == c_ST_START) || (r_state == c_ST_RUN));
    // A done sampled together with the accepting ready finishes the run in START.
    assign w_run_done  = ap_done && ((r_state == c_ST_RUN) || ap_ready);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state      <= c_ST_GAP;
            r_gap_cnt    <= '0;
            r_to_cnt     <= '0;
            r_rep_cnt    <= '0;
            r_csum       <= '0;
            r_run_cnt    <= '0;
            r_err        <= 1'b0;
            r_ap_start   <= 1'b0;
            r_probe      <= 1'b0;
            r_data_out   <= 4'h0;
            r_data_valid <= 1'b0;
        end else begin
            if (w_csum_en) begin
                r_csum <= w_rotl ^ w_word;
            end
            case (r_state)
                c_ST_GAP: begin
                    if (r_gap_cnt != c_GAP_LAST) begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end else if (ap_idle) begin
                        r_state    <= c_ST_START;
                        r_ap_start <= 1'b1;
                        r_probe    <= 1'b1;
                        r_to_cnt   <= '0;
                    end
                end
                c_ST_START, c_ST_RUN: begin
                    if (w_run_done) begin
                        r_run_cnt  <= w_run_next;
                        r_ap_start <= 1'b0;
                        r_probe    <= 1'b0;
                        if (w_more_runs) begin
                            r_state   <= c_ST_GAP;
                            r_gap_cnt <= '0;
                        end else begin
                            r_state      <= c_ST_REPORT;
                            r_data_valid <= 1'b1;
                            r_data_out   <= 4'h0;
                            r_rep_cnt    <= '0;
                        end
                    end else if (r_to_cnt == c_TO_LAST) begin
                        r_err        <= 1'b1;
                        r_ap_start   <= 1'b0;
                        r_probe      <= 1'b0;
                        r_state      <= c_ST_REPORT;
                        r_data_valid <= 1'b1;
                        r_data_out   <= 4'hE;
                        r_rep_cnt    <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                        if ((r_state == c_ST_START) && ap_ready) begin
                            r_ap_start <= 1'b0;
                            r_state    <= c_ST_RUN;
                        end
                    end
                end
                c_ST_REPORT: begin
                    // The checksum is final here, so it is shifted out in place.
                    if (r_rep_cnt != c_REP_LAST) begin
                        r_data_out <= r_csum[CSUM_W-1 -: 4];
                        r_csum     <= r_csum << 4;
                        r_rep_cnt  <= r_rep_cnt + 1'b1;
                    end else begin
                        r_data_valid <= 1'b0;
                        r_data_out   <= 4'h0;
                        r_state      <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_DONE;
                end
                default: begin
                    r_state <= c_ST_GAP;
                end
            endcase
        end
    end

    assign ap_start   = r_ap_start;
    assign probe_out  = r_probe;
    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign run_cnt    = r_run_cnt;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: doc/kernel_run_ctrl.md
Name: kernel_run_ctrl

Overview:
- Sequences the HLS kernel through its ap_ctrl_hs handshake for a fixed number of back-to-back runs after reset.
- Drives probe_out as the activity window marker for power capture.
- Folds every word the kernel writes on its output stream (D_out_din / D_out_write) into a rotate-XOR checksum.
- After the last run, reports a status nibble plus the checksum serially on data_out / data_valid. Sits in the board wrapper between the clock buffer and the kernel instance.

Parameters:
- NUM_RUNS, 16, number of kernel invocations per reset (>= 1)
- START_DELAY, 64, idle cycles after reset and between runs (>= 1)
- TIMEOUT, 1048576, max cycles allowed from start handshake to ap_done
- DOUT_W, 32, kernel output stream width
- CSUM_W, 32, checksum width (multiple of 4)

Ports:
- ap_clk  in  1  single clock, all logic on rising edge
- ap_rst  in  1  synchronous, active-high reset
- ap_start  out  1  kernel start request
- ap_ready  in  1  kernel accepted start
- ap_done  in  1  kernel finished run
- ap_idle  in  1  kernel idle
- dout_write  in  1  kernel output stream write strobe
- dout_din  in  DOUT_W  kernel output stream data
- probe_out  out  1  high while any run is in progress
- data_out  out  4  report nibble
- data_valid  out  1  data_out qualifier
- run_cnt  out  16  completed runs
- err  out  1  sticky timeout flag

Behaviour:
- Reset (ap_rst sampled high at an edge): state=GAP, all outputs 0, gap counter=0, checksum=0, run_cnt=0, err=0, timeout counter=0. Reset mid-run or mid-report aborts immediately; the kernel is reset by the same ap_rst.
- GAP: count START_DELAY cycles. Then, if ap_idle=1, go to START; otherwise stay until ap_idle=1.
- START: ap_start=1 and probe_out=1, held until ap_ready=1 is sampled. On that edge ap_start drops, state -> RUN.
  - If ap_done is also sampled high on that edge, count the run complete directly; no RUN cycle occurs.
- RUN: probe_out=1, ap_start=0. On ap_done=1:
  - run_cnt increments.
  - If run_cnt (new value) < NUM_RUNS -> GAP; else -> REPORT.
  - probe_out falls the cycle after ap_done is sampled.
- Timeout: counter runs in START and RUN and clears on entry to START. On reaching TIMEOUT: err=1, ap_start=0, go straight to REPORT. Remaining runs are skipped.
- Checksum:
  - Updated on every edge where dout_write=1 and state is START or RUN. Writes in any other state are ignored.
  - Update: csum <= rotl1(csum) ^ word, where word is dout_din zero-extended or truncated to CSUM_W.
  - Accumulates across all runs and is not cleared between runs.
  - A write on the same edge as ap_done is still accepted.
- REPORT: 1 + CSUM_W/4 consecutive cycles, data_valid=1 on each.
  - First nibble is status: 0x0 = ok, 0xE = timeout.
  - Then checksum nibbles, MSB nibble first, one per cycle.
  - After the final nibble, data_valid=0 and data_out=0; state -> DONE.
- DONE: terminal state. All outputs hold (probe_out=0, ap_start=0, data_valid=0, run_cnt and err frozen) until the next reset.
- run_cnt saturates at 0xFFFF.
- No combinational path from inputs to outputs; all outputs registered.

Test Plan:
- NUM_RUNS=2, START_DELAY=4, CSUM_W=32. Kernel model: ap_ready 1 cycle after ap_start, ap_done 10 cycles later, 2 writes of 0x00000001 per run -> data_valid for 9 cycles with nibbles 0,0,0,0,0,0,0,0,F; run_cnt=2; err=0; probe_out high in exactly 2 windows.
- Reset release -> ap_start first rises exactly START_DELAY cycles after reset deassertion when ap_idle=1. With ap_idle held 0 for 20 extra cycles, the rise is delayed accordingly.
- ap_ready and ap_done asserted on the same edge as the start handshake -> run counted, no RUN cycle; ap_start is high for exactly 1 cycle.
- TIMEOUT=50, kernel never asserts ap_done -> err=1 at cycle 50 of the run, ap_start=0, run_cnt=0. Report first nibble 0xE, then the checksum of any writes seen so far.
- dout_write pulses during GAP and DONE -> checksum unchanged. A write on the ap_done edge is included (checksum differs from the same test with that write removed).
- ap_rst pulsed for 1 cycle mid-REPORT -> data_valid=0 next cycle, all counters 0, sequence restarts from GAP.
